// File: rtl/vram_write_scheduler_pkg.sv
// Shared definitions for the VRAM write scheduler: FSM states, geometry defaults,
// bus widths and the write payload type.
package vram_write_scheduler_pkg;

    localparam int unsigned CELL_SIZE_DEFAULT    = 64;
    localparam int unsigned BORDER_DEFAULT       = 2;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned COORD_W = 8;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned CELL_W  = 4;

    localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'b000;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  address;
        logic [COLOR_W-1:0] color;
    } pixel_write_t;

endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU write port, cell-fill request port and VRAM write port of the scheduler.
interface vram_write_scheduler_if;
    import vram_write_scheduler_pkg::*;

    logic                iCpuReq;
    logic [ADDR_W-1:0]   iCpuAddr;
    logic [COLOR_W-1:0]  iCpuColor;
    logic                oCpuGrant;

    logic                iFillStart;
    logic [CELL_W-1:0]   iFillCell;
    logic [COLOR_W-1:0]  iFillColor;
    logic                oFillBusy;
    logic                oFillDone;

    logic                oWriteEnable;
    logic [ADDR_W-1:0]   oWriteAddress;
    logic [COLOR_W-1:0]  oDataIn;

    modport master (
        output iCpuReq, iCpuAddr, iCpuColor,
        output iFillStart, iFillCell, iFillColor,
        input  oCpuGrant, oFillBusy, oFillDone,
        input  oWriteEnable, oWriteAddress, oDataIn
    );

    modport slave (
        input  iCpuReq, iCpuAddr, iCpuColor,
        input  iFillStart, iFillCell, iFillColor,
        output oCpuGrant, oFillBusy, oFillDone,
        output oWriteEnable, oWriteAddress, oDataIn
    );

endinterface

// File: rtl/vram_write_scheduler_cell_pixel_counter.sv
// Raster X/Y walker over one CELL_SIZE x CELL_SIZE cell; X runs fastest.
module cell_pixel_counter #(
    parameter  int unsigned CELL_SIZE = 64,
    localparam int unsigned CW        = $clog2(CELL_SIZE)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          iClear,
    input  logic          iEnable,
    output logic [CW-1:0] oX,
    output logic [CW-1:0] oY,
    output logic          oLastPixel_c
);

    localparam logic [CW-1:0] LAST = CW'(CELL_SIZE - 1);

    assign oLastPixel_c = (oX == LAST) && (oY == LAST);

    // Y wraps to zero on its own after the last pixel since CELL_SIZE is a power of two
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            oX <= '0;
            oY <= '0;
        end else if (iClear) begin
            oX <= '0;
            oY <= '0;
        end else if (iEnable) begin
            if (oX == LAST) begin
                oX <= '0;
                oY <= oY + CW'(1);
            end else begin
                oX <= oX + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// Single-port VRAM write arbiter: CPU pixel writes take priority, a cell repaint
// uses the free slots and is guaranteed one slot after STARVE_LIMIT CPU grants.
module vram_write_scheduler
    import vram_write_scheduler_pkg::*;
#(
    parameter int unsigned CELL_SIZE    = CELL_SIZE_DEFAULT,
    parameter int unsigned BORDER       = BORDER_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input logic                   Clock,
    input logic                   Reset,
    vram_write_scheduler_if.slave bus
);

    localparam int unsigned CW = $clog2(CELL_SIZE);
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CW-1:0]      BORDER_LO  = CW'(BORDER);
    localparam logic [CW-1:0]      BORDER_HI  = CW'(CELL_SIZE - BORDER);
    localparam logic [SW-1:0]      STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [COORD_W-1:0] CELL_PITCH = COORD_W'(CELL_SIZE);

    fill_state_t         state;
    fill_state_t         stateNext;
    logic [SW-1:0]       starveCount;
    logic [CELL_W-1:0]   fillCell;
    logic [COLOR_W-1:0]  fillColor;
    logic [CW-1:0]       pixelX;
    logic [CW-1:0]       pixelY;
    logic                lastPixel;
    logic                cpuGrant;
    logic                fillSlot;
    logic                fillAccept;
    logic [COORD_W-1:0]  fillColumn;
    logic [COORD_W-1:0]  fillRow;
    logic                onBorder;
    pixel_write_t        slotWrite;

    cell_pixel_counter #(
        .CELL_SIZE (CELL_SIZE)
    ) u_pixel_counter (
        .Clock        (Clock),
        .Reset        (Reset),
        .iClear       (fillAccept),
        .iEnable      (fillSlot),
        .oX           (pixelX),
        .oY           (pixelY),
        .oLastPixel_c (lastPixel)
    );

    // Slot arbitration and next state
    always_comb begin
        stateNext  = state;
        cpuGrant   = 1'b0;
        fillSlot   = 1'b0;
        fillAccept = 1'b0;
        if (Reset) begin
            cpuGrant = bus.iCpuReq && !((state == FILL) && (starveCount == STARVE_MAX));
            fillSlot = (state == FILL) && !cpuGrant;
        end
        case (state)
            IDLE: begin
                if (bus.iFillStart) begin
                    fillAccept = 1'b1;
                    stateNext  = FILL;
                end
            end
            FILL: begin
                if (fillSlot && lastPixel) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Pixel chosen for this slot: the CPU write if granted, else the current fill pixel
    always_comb begin
        fillColumn = COORD_W'(fillCell[1:0]) * CELL_PITCH + COORD_W'(pixelX);
        fillRow    = COORD_W'(fillCell[3:2]) * CELL_PITCH + COORD_W'(pixelY);
        onBorder   = (pixelX < BORDER_LO) || (pixelX >= BORDER_HI) ||
                     (pixelY < BORDER_LO) || (pixelY >= BORDER_HI);
        slotWrite.address = {fillColumn, fillRow};
        slotWrite.color   = onBorder ? COLOR_BLACK : fillColor;
        if (cpuGrant) begin
            slotWrite.address = bus.iCpuAddr;
            slotWrite.color   = bus.iCpuColor;
        end
    end

    assign bus.oCpuGrant = cpuGrant;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            starveCount       <= '0;
            fillCell          <= '0;
            fillColor         <= '0;
            bus.oWriteEnable  <= 1'b0;
            bus.oWriteAddress <= '0;
            bus.oDataIn       <= '0;
            bus.oFillBusy     <= 1'b0;
            bus.oFillDone     <= 1'b0;
        end else begin
            if (fillAccept) begin
                fillCell    <= bus.iFillCell;
                fillColor   <= bus.iFillColor;
                starveCount <= '0;
            end else if (fillSlot) begin
                starveCount <= '0;
            end else if ((state == FILL) && cpuGrant) begin
                starveCount <= starveCount + SW'(1);
            end

            // Address and data hold their last value on idle cycles
            bus.oWriteEnable <= cpuGrant || fillSlot;
            if (cpuGrant || fillSlot) begin
                bus.oWriteAddress <= slotWrite.address;
                bus.oDataIn       <= slotWrite.color;
            end

            bus.oFillBusy <= (stateNext == FILL);
            bus.oFillDone <= fillSlot && lastPixel;
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Self-checking bench for vram_write_scheduler: a cycle model feeds a scoreboard of
// expected output registers, and scenario tasks check the headline behaviours.
`timescale 1ns/1ps
module tb_vram_write_scheduler;
    import vram_write_scheduler_pkg::*;

    localparam int CS = 64;
    localparam int BD = 2;
    localparam int SL = 4;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    vram_write_scheduler_if bus();

    vram_write_scheduler #(
        .CELL_SIZE    (CS),
        .BORDER       (BD),
        .STARVE_LIMIT (SL)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [2:0]  data;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    bit          mFill = 1'b0;
    int          mX = 0, mY = 0, mStarve = 0;
    logic [3:0]  mCell = '0;
    logic [2:0]  mColor = '0;
    logic [15:0] mLastAddr = '0;
    logic [2:0]  mLastData = '0;

    // Reference model: evaluated mid-cycle with inputs stable, predicts next cycle's registers
    always @(negedge Clock) begin
        exp_t       e;
        bit         expGrant;
        bit         wasFill;
        logic [7:0] col;
        logic [7:0] row;
        wasFill  = mFill;
        expGrant = (Reset === 1'b1) && (bus.iCpuReq === 1'b1) && !(mFill && mStarve == SL);
        checks++;
        if (bus.oCpuGrant !== expGrant) begin
            errors++;
            $display("FAIL grant @%0t: got %b expected %b", $time, bus.oCpuGrant, expGrant);
        end
        e = '0;
        if (Reset !== 1'b1) begin
            mFill = 1'b0; mX = 0; mY = 0; mStarve = 0;
            mLastAddr = '0; mLastData = '0;
        end else begin
            e.addr = mLastAddr;
            e.data = mLastData;
            if (expGrant) begin
                e.we = 1'b1; e.addr = bus.iCpuAddr; e.data = bus.iCpuColor;
                if (mFill) mStarve++;
            end else if (mFill) begin
                col = 8'(int'(mCell[1:0]) * CS + mX);
                row = 8'(int'(mCell[3:2]) * CS + mY);
                e.we   = 1'b1;
                e.addr = {col, row};
                e.data = (mX < BD || mX >= CS - BD || mY < BD || mY >= CS - BD) ? 3'b000 : mColor;
                mStarve = 0;
                if (mX == CS - 1 && mY == CS - 1) begin
                    e.done = 1'b1; mFill = 1'b0; mX = 0; mY = 0;
                end else if (mX == CS - 1) begin
                    mX = 0; mY++;
                end else begin
                    mX++;
                end
            end
            if (!wasFill && bus.iFillStart === 1'b1) begin
                mFill = 1'b1; mCell = bus.iFillCell; mColor = bus.iFillColor;
                mX = 0; mY = 0; mStarve = 0;
            end
            e.busy = mFill;
            mLastAddr = e.addr;
            mLastData = e.data;
        end
        sbq.push_back(e);
    end

    // Scoreboard: compare every registered output against the model's prediction
    always @(posedge Clock) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn, bus.oFillBusy, bus.oFillDone} !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got we=%b addr=%h data=%b busy=%b done=%b expected we=%b addr=%h data=%b busy=%b done=%b",
                         $time, bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn, bus.oFillBusy, bus.oFillDone,
                         e.we, e.addr, e.data, e.busy, e.done);
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.iCpuReq = 1'b1; bus.iCpuAddr = 16'hFFFF; bus.iCpuColor = 3'b111;
        bus.iFillStart = 1'b1; bus.iFillCell = 4'hF; bus.iFillColor = 3'b111;
        repeat (3) begin
            @(negedge Clock);
            checks++;
            if (bus.oCpuGrant !== 1'b0) begin
                errors++; $display("FAIL reset_grant: got %b expected 0", bus.oCpuGrant);
            end
            next_cycle();
            checks++;
            if ({bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn, bus.oFillBusy, bus.oFillDone} !== 22'd0) begin
                errors++;
                $display("FAIL reset_outputs: got we=%b addr=%h data=%b busy=%b done=%b expected all zero",
                         bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn, bus.oFillBusy, bus.oFillDone);
            end
        end
        bus.iCpuReq = 1'b0; bus.iFillStart = 1'b0;
        Reset = 1'b1;
    endtask

    task automatic test_cpu_write();
        bus.iCpuReq = 1'b1; bus.iCpuAddr = 16'h1020; bus.iCpuColor = 3'b101;
        @(negedge Clock);
        checks++;
        if (bus.oCpuGrant !== 1'b1) begin
            errors++; $display("FAIL cpu_grant: got %b expected 1", bus.oCpuGrant);
        end
        next_cycle();
        bus.iCpuReq = 1'b0;
        checks++;
        if (bus.oWriteEnable !== 1'b1 || bus.oWriteAddress !== 16'h1020 || bus.oDataIn !== 3'b101) begin
            errors++; $display("FAIL cpu_write: got we=%b addr=%h data=%b expected 1 1020 101",
                               bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn);
        end
        next_cycle();
        checks++;
        if (bus.oWriteEnable !== 1'b0 || bus.oWriteAddress !== 16'h1020 || bus.oDataIn !== 3'b101) begin
            errors++; $display("FAIL cpu_hold: got we=%b addr=%h data=%b expected 0 1020 101",
                               bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn);
        end
    endtask

    task automatic test_fill();
        int writes = 0, firstCyc = -1, lastCyc = -1;
        logic [15:0] firstAddr = '0, lastAddr = '0;
        logic [2:0]  firstData = '1, interiorData = '1;
        bit doneSeen = 1'b0, doneWithLast = 1'b0;
        bus.iFillStart = 1'b1; bus.iFillCell = 4'b0110; bus.iFillColor = 3'b010;
        next_cycle();
        bus.iFillStart = 1'b0;
        checks++;
        if (bus.oFillBusy !== 1'b1) begin
            errors++; $display("FAIL fill_busy_rise: got %b expected 1", bus.oFillBusy);
        end
        for (int cyc = 0; cyc < 5000 && !doneSeen; cyc++) begin
            next_cycle();
            if (bus.oWriteEnable === 1'b1) begin
                if (writes == 0) begin
                    firstAddr = bus.oWriteAddress; firstData = bus.oDataIn; firstCyc = cyc;
                end
                if (bus.oWriteAddress == 16'h8242) interiorData = bus.oDataIn;
                lastAddr = bus.oWriteAddress; lastCyc = cyc;
                writes++;
            end
            if (bus.oFillDone === 1'b1) begin
                doneSeen = 1'b1;
                doneWithLast = (bus.oWriteEnable === 1'b1) && (bus.oWriteAddress == 16'hBF7F);
            end
        end
        checks++;
        if (!doneSeen) begin errors++; $display("FAIL fill_timeout: no done pulse within 5000 cycles"); end
        checks++;
        if (writes != 4096 || lastCyc - firstCyc != 4095) begin
            errors++; $display("FAIL fill_count: got %0d writes over %0d cycles expected 4096 over 4096",
                               writes, lastCyc - firstCyc + 1);
        end
        checks++;
        if (firstAddr !== 16'h8040 || firstData !== 3'b000) begin
            errors++; $display("FAIL fill_first: got %h/%b expected 8040/000", firstAddr, firstData);
        end
        checks++;
        if (interiorData !== 3'b010) begin
            errors++; $display("FAIL fill_interior: got %b expected 010", interiorData);
        end
        checks++;
        if (lastAddr !== 16'hBF7F || !doneWithLast) begin
            errors++; $display("FAIL fill_last: got addr %h done_with_last=%b expected BF7F 1", lastAddr, doneWithLast);
        end
        next_cycle();
        checks++;
        if (bus.oFillDone !== 1'b0 || bus.oFillBusy !== 1'b0) begin
            errors++; $display("FAIL fill_end: got done=%b busy=%b expected 0 0", bus.oFillDone, bus.oFillBusy);
        end
    endtask

    task automatic test_starve();
        int slots = 0, cpuSlots = 0, fillSlots = 0, run = 0, badRuns = 0;
        bit doneSeen = 1'b0;
        bus.iFillStart = 1'b1; bus.iFillCell = 4'b0000; bus.iFillColor = 3'b111;
        next_cycle();
        bus.iFillStart = 1'b0;
        bus.iCpuReq = 1'b1;
        while (slots < 25000 && !doneSeen) begin
            bus.iCpuAddr = 16'($urandom); bus.iCpuColor = 3'($urandom);
            @(negedge Clock);
            slots++;
            if (bus.oCpuGrant === 1'b1) begin
                cpuSlots++; run++;
            end else begin
                fillSlots++;
                if (run != SL) badRuns++;
                run = 0;
            end
            next_cycle();
            if (bus.oFillDone === 1'b1) doneSeen = 1'b1;
        end
        bus.iCpuReq = 1'b0;
        checks++;
        if (!doneSeen) begin errors++; $display("FAIL starve_timeout: no done pulse within 25000 slots"); end
        checks++;
        if (slots != 20480 || cpuSlots != 16384 || fillSlots != 4096) begin
            errors++; $display("FAIL starve_slots: got %0d slots cpu=%0d fill=%0d expected 20480 16384 4096",
                               slots, cpuSlots, fillSlots);
        end
        checks++;
        if (badRuns != 0) begin
            errors++; $display("FAIL starve_pattern: got %0d fill slots not preceded by %0d grants expected 0", badRuns, SL);
        end
    endtask

    task automatic test_ignore_start();
        int writes = 0, outside = 0, wrongColor = 0;
        bit doneSeen = 1'b0;
        bus.iFillStart = 1'b1; bus.iFillCell = 4'b0000; bus.iFillColor = 3'b011;
        next_cycle();
        bus.iFillStart = 1'b0;
        for (int cyc = 0; cyc < 5000 && !doneSeen; cyc++) begin
            if (cyc == 50) begin
                bus.iFillStart = 1'b1; bus.iFillCell = 4'b1111; bus.iFillColor = 3'b100;
            end else begin
                bus.iFillStart = 1'b0;
            end
            next_cycle();
            if (bus.oWriteEnable === 1'b1) begin
                writes++;
                if (bus.oWriteAddress[15:8] > 8'd63 || bus.oWriteAddress[7:0] > 8'd63) outside++;
                if (bus.oDataIn == 3'b100) wrongColor++;
            end
            if (bus.oFillDone === 1'b1) doneSeen = 1'b1;
        end
        bus.iFillStart = 1'b0;
        checks++;
        if (!doneSeen || writes != 4096) begin
            errors++; $display("FAIL ignore_count: got done=%b writes=%0d expected 1 4096", doneSeen, writes);
        end
        checks++;
        if (outside != 0 || wrongColor != 0) begin
            errors++; $display("FAIL ignore_region: got %0d out-of-cell and %0d wrong-colour writes expected 0 0",
                               outside, wrongColor);
        end
    endtask

    task automatic test_reset_abort();
        int writes = 0;
        bit doneSeen = 1'b0, firstSeen = 1'b0;
        logic [15:0] firstAddr = '0;
        logic [2:0]  firstData = '1;
        bus.iFillStart = 1'b1; bus.iFillCell = 4'b0101; bus.iFillColor = 3'b110;
        next_cycle();
        bus.iFillStart = 1'b0;
        for (int cyc = 0; cyc < 500 && writes < 100; cyc++) begin
            next_cycle();
            if (bus.oWriteEnable === 1'b1) writes++;
            if (bus.oFillDone === 1'b1) doneSeen = 1'b1;
        end
        Reset = 1'b0;
        next_cycle();
        checks++;
        if ({bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn, bus.oFillBusy, bus.oFillDone} !== 22'd0 ||
            writes != 100 || doneSeen) begin
            errors++;
            $display("FAIL abort_outputs: got we=%b addr=%h data=%b busy=%b done=%b writes=%0d early_done=%b expected zeros 100 0",
                     bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn, bus.oFillBusy, bus.oFillDone, writes, doneSeen);
        end
        Reset = 1'b1;
        next_cycle();
        bus.iFillStart = 1'b1; bus.iFillCell = 4'b0101; bus.iFillColor = 3'b110;
        next_cycle();
        bus.iFillStart = 1'b0;
        for (int cyc = 0; cyc < 10 && !firstSeen; cyc++) begin
            next_cycle();
            if (bus.oWriteEnable === 1'b1) begin
                firstSeen = 1'b1; firstAddr = bus.oWriteAddress; firstData = bus.oDataIn;
            end
        end
        checks++;
        if (!firstSeen || firstAddr !== 16'h4040 || firstData !== 3'b000) begin
            errors++; $display("FAIL abort_restart: got seen=%b addr=%h data=%b expected 1 4040 000",
                               firstSeen, firstAddr, firstData);
        end
    endtask

    task automatic test_back_to_back();
        bit doneSeen = 1'b0;
        for (int cyc = 0; cyc < 5000 && !doneSeen; cyc++) begin
            next_cycle();
            if (bus.oFillDone === 1'b1) doneSeen = 1'b1;
        end
        checks++;
        if (!doneSeen) begin errors++; $display("FAIL b2b_timeout: first fill never completed"); end
        // Still inside the done cycle: the new request must be accepted
        bus.iFillStart = 1'b1; bus.iFillCell = 4'b1001; bus.iFillColor = 3'b001;
        next_cycle();
        bus.iFillStart = 1'b0;
        checks++;
        if (bus.oFillBusy !== 1'b1 || bus.oWriteEnable !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b we=%b expected 1 0", bus.oFillBusy, bus.oWriteEnable);
        end
        next_cycle();
        checks++;
        if (bus.oWriteEnable !== 1'b1 || bus.oWriteAddress !== 16'h4080 || bus.oDataIn !== 3'b000) begin
            errors++; $display("FAIL b2b_first: got we=%b addr=%h data=%b expected 1 4080 000",
                               bus.oWriteEnable, bus.oWriteAddress, bus.oDataIn);
        end
        doneSeen = 1'b0;
        for (int cyc = 0; cyc < 5000 && !doneSeen; cyc++) begin
            next_cycle();
            if (bus.oFillDone === 1'b1) doneSeen = 1'b1;
        end
        checks++;
        if (!doneSeen) begin errors++; $display("FAIL b2b_done: second fill never completed"); end
    endtask

    initial begin
        Reset = 1'b0;
        bus.iCpuReq = 1'b0; bus.iCpuAddr = '0; bus.iCpuColor = '0;
        bus.iFillStart = 1'b0; bus.iFillCell = '0; bus.iFillColor = '0;
        test_reset();
        test_cpu_write();
        test_fill();
        test_starve();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        repeat (3) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
